// File: rtl/note_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_seq_ctrl_pkg
// Purpose  : Shared constants for the note record/playback sequencer.
//            Holds the NoteMemory geometry (data width, depth) and the
//            sequencer state codes, which the LED display also decodes.
// Contents : DATA_WIDTH, MAX_DEPTH, MAX_DEPTH_BIT, SEQ_ST_* state codes,
//            note_t type, max_int() helper.
// Revision : 1.0 - initial release
// ============================================================================
package note_seq_ctrl_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int MAX_DEPTH     = 16;
  localparam int MAX_DEPTH_BIT = 4;

  typedef logic [DATA_WIDTH-1:0] note_t;

  // Sequencer state encoding; also shown on the LEDs via state_out.
  localparam logic [2:0] SEQ_ST_IDLE   = 3'd0;
  localparam logic [2:0] SEQ_ST_RECORD = 3'd1;
  localparam logic [2:0] SEQ_ST_P_RST  = 3'd2;
  localparam logic [2:0] SEQ_ST_P_REQ  = 3'd3;
  localparam logic [2:0] SEQ_ST_P_WAIT = 3'd4;
  localparam logic [2:0] SEQ_ST_P_HOLD = 3'd5;
  localparam logic [2:0] SEQ_ST_P_GAP  = 3'd6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : note_seq_ctrl_if
// Purpose  : Bus between the sequencer and NoteMemory.
// Signals  : mem_write_en, mem_read_en, mem_read_rst, mem_data_in
//              (sequencer -> memory)
//            mem_data_out, mem_output_ready (memory -> sequencer)
// Modports : master (sequencer side), slave (NoteMemory side)
// Revision : 1.0 - initial release
// ============================================================================
interface note_seq_ctrl_if
  import note_seq_ctrl_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) ();

  logic          mem_write_en;
  logic          mem_read_en;
  logic          mem_read_rst;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_output_ready;

  modport master (
    output mem_write_en,
    output mem_read_en,
    output mem_read_rst,
    output mem_data_in,
    input  mem_data_out,
    input  mem_output_ready
  );

  modport slave (
    input  mem_write_en,
    input  mem_read_en,
    input  mem_read_rst,
    input  mem_data_in,
    output mem_data_out,
    output mem_output_ready
  );

endinterface
`default_nettype wire

// File: rtl/note_seq_ctrl_beat_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : beat_tick_gen
// Purpose  : Divides clk down to a timing tick. The counter runs modulo
//            TICK_DIV and tick is high in the cycle where it sits at
//            TICK_DIV-1. clr holds the counter at 0 so the first tick after
//            release arrives exactly TICK_DIV cycles later.
// Ports    : clk   - system clock
//            rst_n - async active-low reset
//            clr   - synchronous counter clear
//            tick  - one-cycle tick pulse
// Revision : 1.0 - initial release
// ============================================================================
module beat_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  output logic      tick
);

  localparam int             c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Not gated by clr: the caller derives clr from this tick, and the
  // counter is already 0 whenever clr was active the cycle before.
  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/note_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : note_seq_ctrl
// Purpose  : Record/playback sequencer for NoteMemory. RECORD streams live
//            key codes into memory; PLAY reads the stored notes back one at
//            a time, holds each for NOTE_TICKS ticks followed by GAP_TICKS
//            silent ticks, and drives them to the tone generator.
// Ports    : clk, rst_n             - clock, async active-low reset
//            rec_start/play_start/stop - 1-cycle command pulses
//            key_note                - live key code (0 = no key)
//            mem                     - NoteMemory bus (master modport)
//            note_out                - code to tone generator (0 = silence)
//            busy                    - high in any state but IDLE
//            state_out               - current state code for the LEDs
// Options  : LOOP_PLAYBACK_EN - when defined, playback restarts from the
//            first note after the last one until stop (empty memory still
//            returns to IDLE).
// Revision : 1.0 - initial release
// ============================================================================
module note_seq_ctrl
  import note_seq_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int NOTE_TICKS = 250,
  parameter int GAP_TICKS  = 20,
  parameter int DW         = DATA_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          rec_start,
  input  wire logic          play_start,
  input  wire logic          stop,
  input  wire logic [DW-1:0] key_note,
  note_seq_ctrl_if.master    mem,
  output logic      [DW-1:0] note_out,
  output logic               busy,
  output logic      [2:0]    state_out
);

  localparam int c_BEAT_MAX = max_int(NOTE_TICKS, GAP_TICKS);
  localparam int c_BEAT_W   = $clog2(c_BEAT_MAX + 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_SAT  = {c_BEAT_W{1'b1}};
  localparam logic [c_BEAT_W-1:0] c_NOTE_LAST = c_BEAT_W'(NOTE_TICKS - 1);
  localparam logic [c_BEAT_W-1:0] c_GAP_LAST  =
    c_BEAT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [2:0]          w_after_hold;
  logic [2:0]          w_after_empty;
  logic [DW-1:0]       r_note;
  logic [DW-1:0]       w_note_next;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_BEAT_W-1:0] w_beat_last;
  logic                w_in_timed;
  logic                w_timer_clr;
  logic                w_tick;
  logic                w_beat_done;

  // --------------------------------------------------------------------------
  // Beat timing: the tick divider and beat counter only run while a note or
  // gap is being timed, and restart from zero on every state change.
  // --------------------------------------------------------------------------
  assign w_in_timed  = (r_state == SEQ_ST_P_HOLD) || (r_state == SEQ_ST_P_GAP);
  assign w_timer_clr = !w_in_timed || (w_state_next != r_state);

  beat_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_beat_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_timer_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_timer_clr) begin
      r_beat <= '0;
    end else if (w_tick && (r_beat != c_BEAT_SAT)) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign w_beat_last = (r_state == SEQ_ST_P_HOLD) ? c_NOTE_LAST : c_GAP_LAST;
  assign w_beat_done = w_tick && (r_beat == w_beat_last);

  // Legato playback skips the gap state entirely.
  generate
    if (GAP_TICKS == 0) begin : g_legato
      assign w_after_hold = SEQ_ST_P_REQ;
    end else begin : g_gap
      assign w_after_hold = SEQ_ST_P_GAP;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Where playback goes when the memory reports no further note.
  // --------------------------------------------------------------------------
`ifdef LOOP_PLAYBACK_EN
  logic r_played;

  // Remembers whether this pass produced a note, so an empty memory does
  // not spin forever between P_RST and P_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_played <= 1'b0;
    end else if ((r_state == SEQ_ST_IDLE) || (r_state == SEQ_ST_P_RST)) begin
      r_played <= 1'b0;
    end else if ((r_state == SEQ_ST_P_WAIT) && mem.mem_output_ready) begin
      r_played <= 1'b1;
    end
  end

  assign w_after_empty = r_played ? SEQ_ST_P_RST : SEQ_ST_IDLE;
`else
  assign w_after_empty = SEQ_ST_IDLE;
`endif

  // --------------------------------------------------------------------------
  // State machine. stop wins over everything; start commands only in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_ST_IDLE: begin
        if (!stop) begin
          if (rec_start) begin
            w_state_next = SEQ_ST_RECORD;
          end else if (play_start) begin
            w_state_next = SEQ_ST_P_RST;
          end
        end
      end
      SEQ_ST_RECORD: begin
        if (stop) begin
          w_state_next = SEQ_ST_IDLE;
        end
      end
      SEQ_ST_P_RST: begin
        w_state_next = stop ? SEQ_ST_IDLE : SEQ_ST_P_REQ;
      end
      SEQ_ST_P_REQ: begin
        w_state_next = stop ? SEQ_ST_IDLE : SEQ_ST_P_WAIT;
      end
      SEQ_ST_P_WAIT: begin
        if (stop) begin
          w_state_next = SEQ_ST_IDLE;
        end else if (mem.mem_output_ready) begin
          w_state_next = SEQ_ST_P_HOLD;
        end else begin
          w_state_next = w_after_empty;
        end
      end
      SEQ_ST_P_HOLD: begin
        if (stop) begin
          w_state_next = SEQ_ST_IDLE;
        end else if (w_beat_done) begin
          w_state_next = w_after_hold;
        end
      end
      SEQ_ST_P_GAP: begin
        if (stop) begin
          w_state_next = SEQ_ST_IDLE;
        end else if (w_beat_done) begin
          w_state_next = SEQ_ST_P_REQ;
        end
      end
      default: begin
        w_state_next = SEQ_ST_IDLE;
      end
    endcase
  end

  // The output note is non-zero only while holding: it is captured on entry
  // to P_HOLD and cleared on any exit, which also covers stop.
  always_comb begin
    w_note_next = '0;
    if ((r_state == SEQ_ST_P_WAIT) && (w_state_next == SEQ_ST_P_HOLD)) begin
      w_note_next = mem.mem_data_out;
    end else if ((r_state == SEQ_ST_P_HOLD) && (w_state_next == SEQ_ST_P_HOLD)) begin
      w_note_next = r_note;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_ST_IDLE;
      r_note  <= '0;
    end else begin
      r_state <= w_state_next;
      r_note  <= w_note_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Memory strobes decode directly from the state register, so a
  // reset removes them immediately and read_en/read_rst can never overlap.
  // --------------------------------------------------------------------------
  assign mem.mem_write_en = (r_state == SEQ_ST_RECORD);
  assign mem.mem_data_in  = (r_state == SEQ_ST_RECORD) ? key_note : '0;
  assign mem.mem_read_rst = (r_state == SEQ_ST_P_RST);
  assign mem.mem_read_en  = (r_state == SEQ_ST_P_REQ);

  assign note_out  = r_note;
  assign busy      = (r_state != SEQ_ST_IDLE);
  assign state_out = r_state;

endmodule
`default_nettype wire
